// File: rtl/scan_cfg_loader.sv
// Host byte stream -> CLB or connection scan chain loader, with chain readback.
// Stream: CMD, LEN_HI, LEN_LO, then ceil(LEN/8) LSB-first data bytes; 8 bits per 9 cycles when streaming.
module scan_cfg_loader #(
  parameter int LEN_W = 16
) (
  input  logic       scan_clk,
  input  logic       rst_n,
  input  logic [7:0] cfg_data,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       clb_scan_in,
  output logic       clb_scan_en,
  input  logic       clb_scan_out,
  output logic       conn_scan_in,
  output logic       conn_scan_en,
  input  logic       conn_scan_out,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_LOAD, S_DONE} state_t;

  state_t           state_q;
  logic             sel_q;
  logic [7:0]       len_hi_q;
  logic [LEN_W-1:0] rem_q;
  logic [7:0]       buf_q;
  logic [3:0]       bcnt_q;
  logic [7:0]       col_q;
  logic [2:0]       sidx_q;
  logic             clb_in_q, clb_en_q, conn_in_q, conn_en_q;
  logic             rd_valid_q, done_q, err_q;
  logic [7:0]       rd_data_q;

  logic             xfer, shift, smp_en, smp_bit, last_smp;
  logic [LEN_W-1:0] len_d;
  logic [3:0]       ld_cnt_d;
  logic [7:0]       col_d;

  always_comb begin
    cfg_ready = 1'b0;
    case (state_q)
      S_IDLE, S_LEN_HI, S_LEN_LO: cfg_ready = 1'b1;
      S_LOAD:  cfg_ready = (bcnt_q == 4'd0) && (rem_q != '0);
      default: cfg_ready = 1'b0;
    endcase
  end

  assign xfer     = cfg_valid && cfg_ready;
  assign shift    = (state_q == S_LOAD) && (bcnt_q != 4'd0);
  assign smp_en   = sel_q ? conn_en_q : clb_en_q;
  assign smp_bit  = sel_q ? conn_scan_out : clb_scan_out;
  // rem_q already counts the bit being sampled, so zero marks the final sample.
  assign last_smp = (sidx_q == 3'd7) || (rem_q == '0);
  assign len_d    = LEN_W'({len_hi_q, cfg_data});
  assign ld_cnt_d = (rem_q >= LEN_W'(8)) ? 4'd8 : rem_q[3:0];

  always_comb begin
    col_d         = col_q;
    col_d[sidx_q] = smp_bit;
  end

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= 1'b0;
      len_hi_q   <= '0;
      rem_q      <= '0;
      buf_q      <= '0;
      bcnt_q     <= '0;
      col_q      <= '0;
      sidx_q     <= '0;
      clb_in_q   <= 1'b0;
      clb_en_q   <= 1'b0;
      conn_in_q  <= 1'b0;
      conn_en_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clb_en_q   <= shift && !sel_q;
      clb_in_q   <= shift && !sel_q && buf_q[0];
      conn_en_q  <= shift && sel_q;
      conn_in_q  <= shift && sel_q && buf_q[0];
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;

      if (smp_en) begin
        if (last_smp) begin
          rd_data_q  <= col_d;
          rd_valid_q <= 1'b1;
          col_q      <= '0;
          sidx_q     <= '0;
        end else begin
          col_q  <= col_d;
          sidx_q <= sidx_q + 3'd1;
        end
      end

      case (state_q)
        S_IDLE: if (xfer) begin
          if (cfg_data[7:1] != 7'd0) begin
            err_q <= 1'b1;
          end else begin
            err_q   <= 1'b0;
            sel_q   <= cfg_data[0];
            state_q <= S_LEN_HI;
          end
        end
        S_LEN_HI: if (xfer) begin
          len_hi_q <= cfg_data;
          state_q  <= S_LEN_LO;
        end
        S_LEN_LO: if (xfer) begin
          rem_q <= len_d;
          if (len_d == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (shift) begin
            buf_q  <= {1'b0, buf_q[7:1]};
            bcnt_q <= bcnt_q - 4'd1;
            rem_q  <= rem_q - LEN_W'(1);
          end else if (xfer) begin
            buf_q  <= cfg_data;
            bcnt_q <= ld_cnt_d;
          end else if (rem_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign clb_scan_in  = clb_in_q;
  assign clb_scan_en  = clb_en_q;
  assign conn_scan_in = conn_in_q;
  assign conn_scan_en = conn_en_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_scan_cfg_loader.sv
// Bench for scan_cfg_loader: queue-based model of shifted bits and readback bytes,
// 16-bit shift-register models of both chains, directed load scenarios.
module tb_scan_cfg_loader;

  logic       scan_clk = 1'b0;
  logic       rst_n;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       clb_scan_in, clb_scan_en, clb_scan_out;
  logic       conn_scan_in, conn_scan_en, conn_scan_out;
  logic [7:0] rd_data;
  logic       rd_valid, busy, done, err;

  always #5 scan_clk = ~scan_clk;

  scan_cfg_loader #(.LEN_W(16)) dut (
    .scan_clk     (scan_clk),
    .rst_n        (rst_n),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .clb_scan_in  (clb_scan_in),
    .clb_scan_en  (clb_scan_en),
    .clb_scan_out (clb_scan_out),
    .conn_scan_in (conn_scan_in),
    .conn_scan_en (conn_scan_en),
    .conn_scan_out(conn_scan_out),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  // Chains: the core shifts on the edge after the loader presents scan_in/scan_en.
  logic [15:0] clb_ch, conn_ch, clb_pre, conn_pre;
  logic        ch_load;
  always @(posedge scan_clk) begin
    if (ch_load) begin
      clb_ch  <= clb_pre;
      conn_ch <= conn_pre;
    end else begin
      if (clb_scan_en)  clb_ch  <= {clb_scan_in, clb_ch[15:1]};
      if (conn_scan_en) conn_ch <= {conn_scan_in, conn_ch[15:1]};
    end
  end
  assign clb_scan_out  = clb_ch[0];
  assign conn_scan_out = conn_ch[0];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  logic       exp_sel = 1'b0;
  logic       exp_bits[$];
  logic [7:0] exp_rd[$];
  logic       obs_bits[$];
  logic [7:0] obs_rd[$];
  int         en_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm, input string what);
    checks++;
    errors++;
    $display("FAIL %s %s", nm, what);
  endtask

  task automatic compare_loop();
    logic sel_en, sel_in;
    forever begin
      @(negedge scan_clk);
      cyc++;
      sel_en = exp_sel ? conn_scan_en : clb_scan_en;
      sel_in = exp_sel ? conn_scan_in : clb_scan_in;
      if (exp_sel) chk("unsel_clb", 32'({clb_scan_en, clb_scan_in}), 32'h0);
      else         chk("unsel_conn", 32'({conn_scan_en, conn_scan_in}), 32'h0);
      if (sel_en === 1'b1) begin
        en_cyc.push_back(cyc);
        obs_bits.push_back(sel_in);
        if (exp_bits.size() == 0) fail("scan_bit", "actual=extra shift required=none");
        else chk("scan_bit", 32'(sel_in), 32'(exp_bits.pop_front()));
      end
      if (rd_valid === 1'b1) begin
        obs_rd.push_back(rd_data);
        if (exp_rd.size() == 0) fail("rd_data", "actual=extra byte required=none");
        else begin
          chk("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
          chk("done_vs_last_rd", 32'(done), 32'(exp_rd.size() == 0));
        end
      end
      if (done === 1'b1) done_cnt++;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    cfg_data  = b;
    cfg_valid = 1'b1;
    while (cfg_ready !== 1'b1 && n < 300) begin
      @(negedge scan_clk);
      n++;
    end
    if (n >= 300) fail("send", "actual=cfg_ready stuck low required=accept");
    @(negedge scan_clk);
  endtask

  task automatic do_load(input logic [7:0] cmd, input int len, input logic [15:0] dw, input int gap);
    logic [31:0] m;
    int          nb, n, d0;
    exp_sel = cmd[0];
    for (int i = 0; i < len; i++) exp_bits.push_back(dw[i]);
    m  = {16'h0, (cmd[0] ? conn_pre : clb_pre)} & ((32'h1 << len) - 32'h1);
    nb = (len + 7) / 8;
    for (int k = 0; k < nb; k++) exp_rd.push_back(m[8*k +: 8]);
    ch_load = 1'b1;
    @(negedge scan_clk);
    ch_load = 1'b0;
    d0 = done_cnt;
    send(cmd);
    send(8'(len >> 8));
    send(8'(len));
    for (int k = 0; k < nb; k++) begin
      if (k == 1 && gap > 0) begin
        cfg_valid = 1'b0;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 100) begin
          @(negedge scan_clk);
          n++;
        end
        repeat (gap) @(negedge scan_clk);
      end
      send(dw[8*k +: 8]);
    end
    cfg_valid = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      @(negedge scan_clk);
      n++;
    end
    if (n >= 400) fail("load_done", "actual=no done required=done pulse");
    repeat (2) @(negedge scan_clk);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("bits_left", 32'(exp_bits.size()), 32'd0);
    chk("rd_left", 32'(exp_rd.size()), 32'd0);
  endtask

  task automatic check_run(input string nm, input int b0, input int e0, input logic [15:0] expv, input int gap);
    logic [15:0] v = '0;
    if (obs_bits.size() < b0 + 10 || en_cyc.size() < e0 + 10) begin
      fail(nm, "actual=short shift run required=10 bits");
    end else begin
      for (int i = 0; i < 10; i++) v[i] = obs_bits[b0 + i];
      chk({nm, "_seq"}, 32'(v), 32'(expv));
      for (int k = 1; k < 10; k++)
        chk({nm, "_timing"}, 32'(en_cyc[e0 + k] - en_cyc[e0]), 32'((k < 8) ? k : k + 1 + gap));
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_ready"}, 32'(cfg_ready), 32'd1);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_err"}, 32'(err), 32'd0);
    chk({nm, "_rdv"}, 32'(rd_valid), 32'd0);
    chk({nm, "_scan"}, 32'({clb_scan_en, clb_scan_in, conn_scan_en, conn_scan_in}), 32'd0);
  endtask

  initial begin
    int b0, e0, r0, n;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    clb_pre   = 16'h0000;
    conn_pre  = 16'h0000;
    ch_load   = 1'b1;
    fork
      compare_loop();
    join_none
    repeat (3) @(negedge scan_clk);
    ch_load = 1'b0;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge scan_clk);

    // CLB load: 10 bits from 0xA5,0x03.
    b0 = obs_bits.size(); e0 = en_cyc.size();
    do_load(8'h00, 10, 16'h03A5, 0);
    check_run("clb", b0, e0, 16'h03A5, 0);

    // Connection chain readback of preload 0x2B6.
    conn_pre = 16'h02B6;
    r0 = obs_rd.size();
    do_load(8'h01, 10, 16'h013C, 0);
    if (obs_rd.size() >= r0 + 2) begin
      chk("rb_byte0", 32'(obs_rd[r0]), 32'h0B6);
      chk("rb_byte1", 32'(obs_rd[r0 + 1]), 32'h002);
    end else fail("rb_count", "actual=fewer than 2 bytes required=2");

    // Bad command, then a good one finished with zero length.
    exp_sel = 1'b1;
    send(8'h05);
    cfg_valid = 1'b0;
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_busy", 32'(busy), 32'd0);
    send(8'h01);
    cfg_valid = 1'b0;
    chk("good_err", 32'(err), 32'd0);
    chk("good_busy", 32'(busy), 32'd1);
    chk("good_ready", 32'(cfg_ready), 32'd1);
    send(8'h00);
    send(8'h00);
    cfg_valid = 1'b0;
    chk("good_done", 32'(done), 32'd1);
    @(negedge scan_clk);

    // Asynchronous reset mid-idle clears the sticky err immediately.
    exp_sel = 1'b0;
    send(8'h80);
    cfg_valid = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("rst_idle");
    @(negedge scan_clk);
    rst_n = 1'b1;
    @(negedge scan_clk);

    // Zero-length load: done the cycle after LEN_LO, no shifting, no readback.
    r0 = obs_rd.size(); e0 = en_cyc.size();
    send(8'h00);
    send(8'h00);
    send(8'h00);
    cfg_valid = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_ready", 32'(cfg_ready), 32'd0);
    chk("zero_busy", 32'(busy), 32'd1);
    @(negedge scan_clk);
    chk("zero_done_clr", 32'(done), 32'd0);
    chk("zero_busy_clr", 32'(busy), 32'd0);
    chk("zero_no_rd", 32'(obs_rd.size() - r0), 32'd0);
    chk("zero_no_shift", 32'(en_cyc.size() - e0), 32'd0);

    // Reset after 3 bits of a CLB load.
    exp_sel = 1'b0;
    for (int i = 0; i < 10; i++) exp_bits.push_back(i[0] == 1'b0);
    e0 = en_cyc.size();
    send(8'h00);
    send(8'h00);
    send(8'h0A);
    send(8'h55);
    cfg_valid = 1'b0;
    n = 0;
    while (en_cyc.size() < e0 + 3 && n < 100) begin
      @(negedge scan_clk);
      #1 n++;
    end
    #1 rst_n = 1'b0;
    #1 chk("rst_load_en", 32'(clb_scan_en), 32'd0);
    chk("rst_load_busy", 32'(busy), 32'd0);
    exp_bits.delete();
    exp_rd.delete();
    @(negedge scan_clk);
    rst_n = 1'b1;
    chk("rst_load_bits", 32'(en_cyc.size() - e0), 32'd3);
    @(negedge scan_clk);
    b0 = obs_bits.size(); e0 = en_cyc.size();
    do_load(8'h00, 10, 16'h025C, 0);
    check_run("reload", b0, e0, 16'h025C, 0);

    // Host gap of 5 cycles before the second data byte.
    conn_pre = 16'h0155;
    b0 = obs_bits.size(); e0 = en_cyc.size();
    do_load(8'h01, 10, 16'h03A5, 5);
    check_run("gap", b0, e0, 16'h03A5, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
